// File: rtl/fast_corner_scanner.sv
// FAST corner scanner: walks an image held in the Gaussian-filtered SRAM in
// raster order, classifies every pixel with the 16-point Bresenham circle
// test and writes one corner flag per pixel into the FAST result SRAM.
module fast_corner_scanner #(
  parameter int X_MAX     = 640,
  parameter int Y_MAX     = 480,
  parameter int THRESHOLD = 20,
  parameter int ARC_LEN   = 9,
  parameter int PIX_W     = 8,
  localparam int XW = $clog2(X_MAX) + 1,
  localparam int YW = $clog2(Y_MAX) + 1,
  localparam int CW = $clog2(X_MAX * Y_MAX) + 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             abort,
  input  logic [XW-1:0]    max_x,
  input  logic [YW-1:0]    max_y,
  input  logic [PIX_W-1:0] SRAM_in_gaus,
  output logic             read_SRAM_gaus,
  output logic [XW-1:0]    x_addr_gaus,
  output logic [YW-1:0]    y_addr_gaus,
  output logic             write_SRAM_fast,
  output logic [XW-1:0]    x_addr_fast,
  output logic [YW-1:0]    y_addr_fast,
  output logic             fast_wdata,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    corner_count
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, EVAL, WRITE, DONE} state_t;

  localparam logic signed [PIX_W+1:0] THR = (PIX_W+2)'(THRESHOLD);

  state_t           state_q, state_d;
  logic [XW-1:0]    x_q, mx_q, nx, x_rd;
  logic [YW-1:0]    y_q, my_q, ny, y_rd;
  logic [4:0]       rd_idx_q;
  logic             corner_q, corner_d, last_x, last_pix;
  logic [CW-1:0]    count_q;
  logic [5:0]       rd_off;
  logic [15:0]      bright, dark;
  // slot 0 is the centre, slots 1..16 are circle indices 0..15
  logic [PIX_W-1:0] samp_q [17];

  // A pixel is border when any part of its radius-3 circle leaves the image.
  function automatic logic is_border(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                     input logic [XW-1:0] mx, input logic [YW-1:0] my);
    return (x < XW'(3)) || (y < YW'(3)) ||
           (({1'b0, x} + (XW+1)'(3)) > {1'b0, mx}) ||
           (({1'b0, y} + (YW+1)'(3)) > {1'b0, my});
  endfunction

  // Circle offsets packed as {dx[2:0], dy[2:0]}, two's complement.
  function automatic logic [5:0] ring_off(input logic [3:0] i);
    case (i)
      4'd0:    return 6'b000_101;
      4'd1:    return 6'b001_101;
      4'd2:    return 6'b010_110;
      4'd3:    return 6'b011_111;
      4'd4:    return 6'b011_000;
      4'd5:    return 6'b011_001;
      4'd6:    return 6'b010_010;
      4'd7:    return 6'b001_011;
      4'd8:    return 6'b000_011;
      4'd9:    return 6'b111_011;
      4'd10:   return 6'b110_010;
      4'd11:   return 6'b101_001;
      4'd12:   return 6'b101_000;
      4'd13:   return 6'b101_111;
      4'd14:   return 6'b110_110;
      default: return 6'b111_101;
    endcase
  endfunction

  // True when ARC_LEN circularly adjacent bits of m are all set.
  function automatic logic has_arc(input logic [15:0] m);
    logic found, run;
    logic [3:0] j;
    found = 1'b0;
    for (int s = 0; s < 16; s++) begin
      run = 1'b1;
      for (int k = 0; k < ARC_LEN; k++) begin
        j   = 4'(s + k);
        run = run & m[j];
      end
      found = found | run;
    end
    return found;
  endfunction

  // Read address: centre on the first strobe, then the circle in index order.
  always_comb begin
    rd_off = 6'b0;
    if (rd_idx_q != 5'd0) rd_off = ring_off(4'(rd_idx_q - 5'd1));
    x_rd = x_q + {{(XW-3){rd_off[5]}}, rd_off[5:3]};
    y_rd = y_q + {{(YW-3){rd_off[2]}}, rd_off[2:0]};
  end

  // Bright/dark classification in widened signed arithmetic, then the arc test.
  always_comb begin
    logic signed [PIX_W+1:0] cen, hi, lo, pix;
    cen = $signed({2'b00, samp_q[0]});
    hi  = cen + THR;
    lo  = cen - THR;
    bright = '0;
    dark   = '0;
    for (int i = 0; i < 16; i++) begin
      pix       = $signed({2'b00, samp_q[i+1]});
      bright[i] = pix > hi;
      dark[i]   = pix < lo;
    end
    corner_d = has_arc(bright) || has_arc(dark);
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d  = state_q;
    last_x   = (x_q == mx_q);
    last_pix = last_x && (y_q == my_q);
    nx       = last_x ? '0 : x_q + XW'(1);
    ny       = last_x ? y_q + YW'(1) : y_q;
    case (state_q)
      IDLE:    if (start && !abort) state_d = is_border('0, '0, max_x, max_y) ? WRITE : READ;
      READ:    if (rd_idx_q == 5'd16) state_d = WAIT;
      WAIT:    state_d = EVAL;
      EVAL:    state_d = WRITE;
      WRITE:   if (last_pix) state_d = DONE;
               else state_d = is_border(nx, ny, mx_q, my_q) ? WRITE : READ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) state_d = IDLE;
  end

  // Control state: FSM, pixel position, latched limits, flag and counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      mx_q     <= '0;
      my_q     <= '0;
      rd_idx_q <= '0;
      corner_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start && !abort) begin
          mx_q     <= max_x;
          my_q     <= max_y;
          x_q      <= '0;
          y_q      <= '0;
          rd_idx_q <= '0;
          corner_q <= 1'b0;
          count_q  <= '0;
        end
        READ:  rd_idx_q <= (rd_idx_q == 5'd16) ? 5'd0 : rd_idx_q + 5'd1;
        EVAL:  corner_q <= corner_d;
        WRITE: if (!abort) begin
          if (corner_q && count_q != '1) count_q <= count_q + CW'(1);
          corner_q <= 1'b0;
          x_q      <= nx;
          y_q      <= ny;
        end
        default: ;
      endcase
    end
  end

  // --- sample stage: read data returns one cycle after its strobe ---
  always_ff @(posedge clk) begin
    if (state_q == READ && rd_idx_q != 5'd0) samp_q[rd_idx_q - 5'd1] <= SRAM_in_gaus;
    else if (state_q == WAIT)                samp_q[16] <= SRAM_in_gaus;
  end

  assign read_SRAM_gaus  = (state_q == READ);
  assign x_addr_gaus     = read_SRAM_gaus ? x_rd : '0;
  assign y_addr_gaus     = read_SRAM_gaus ? y_rd : '0;
  assign write_SRAM_fast = (state_q == WRITE);
  assign x_addr_fast     = write_SRAM_fast ? x_q : '0;
  assign y_addr_fast     = write_SRAM_fast ? y_q : '0;
  assign fast_wdata      = write_SRAM_fast & corner_q;
  assign busy            = (state_q == READ) || (state_q == WAIT) ||
                           (state_q == EVAL) || (state_q == WRITE);
  assign done            = (state_q == DONE);
  assign corner_count    = count_q;

endmodule

// File: doc/fast_corner_scanner.md
FAST_CORNER_SCANNER -- requirements
Module: fast_corner_scanner

Interface
REQ-001 SHALL have parameter X_MAX, default 640, meaning maximum image width.
REQ-002 SHALL have parameter Y_MAX, default 480, meaning maximum image height.
REQ-003 SHALL have parameter THRESHOLD, default 20, meaning the intensity margin for bright/dark classification.
REQ-004 SHALL have parameter ARC_LEN, default 9, legal range 9..12, meaning the required contiguous arc length.
REQ-005 SHALL have parameter PIX_W, default 8, meaning pixel bit width; define XW=$clog2(X_MAX)+1, YW=$clog2(Y_MAX)+1, CW=$clog2(X_MAX*Y_MAX)+1.
REQ-006 SHALL have ports: clk in 1 (clock); n_rst in 1 (reset, asynchronous, active-low).
REQ-007 SHALL have ports: start in 1 (begin scan); abort in 1 (cancel scan); max_x in XW and max_y in YW (highest valid pixel index).
REQ-008 SHALL have ports: SRAM_in_gaus in PIX_W (read data); read_SRAM_gaus out 1; x_addr_gaus out XW; y_addr_gaus out YW.
REQ-009 SHALL have ports: write_SRAM_fast out 1; x_addr_fast out XW; y_addr_fast out YW; fast_wdata out 1 (corner flag).
REQ-010 SHALL have ports: busy out 1; done out 1 (one-cycle pulse); corner_count out CW.

Function
REQ-011 SHALL scan pixels in raster order, x from 0 to max_x inner, then y from 0 to max_y, writing exactly one fast_wdata per pixel at (x,y).
REQ-012 SHALL define a border pixel as x<3, y<3, x>max_x-3 or y>max_y-3; border pixels take one WRITE cycle with fast_wdata=0 and no reads.
REQ-013 SHALL use states IDLE, READ, WAIT, EVAL, WRITE, DONE.
REQ-014 SHALL transition IDLE->READ (or ->WRITE for a border pixel) on start, clear corner_count, and set busy from the following cycle until DONE exits.
REQ-015 SHALL in READ, for 17 cycles, assert read_SRAM_gaus with the centre address first, then circle indices 0..15 at offsets (0,-3),(1,-3),(2,-2),(3,-1),(3,0),(3,1),(2,2),(1,3),(0,3),(-1,3),(-2,2),(-3,1),(-3,0),(-3,-1),(-2,-2),(-1,-3).
REQ-016 SHALL sample SRAM_in_gaus one cycle after each read strobe; WAIT (1 cycle) captures the final sample.
REQ-017 SHALL in EVAL mark circle pixel p bright iff p > c+THRESHOLD and dark iff p < c-THRESHOLD, computed in PIX_W+2-bit signed arithmetic without saturation or wrap.
REQ-018 SHALL declare a corner iff ARC_LEN or more circularly contiguous indices are all bright or all dark, with runs wrapping from index 15 to 0.
REQ-019 SHALL in WRITE assert write_SRAM_fast for exactly one cycle with fast_wdata=corner and increment corner_count on a corner, saturating at all-ones.
REQ-020 SHALL take exactly 20 cycles per interior pixel (17 READ, 1 WAIT, 1 EVAL, 1 WRITE) and 1 cycle per border pixel.
REQ-021 SHALL after the WRITE of (max_x,max_y) enter DONE, pulse done for one cycle, deassert busy, and return to IDLE.
REQ-022 SHALL ignore start while busy.
REQ-023 SHALL on abort in any non-IDLE state return to IDLE next cycle, deassert all strobes, not pulse done, and hold corner_count.
REQ-024 SHALL give abort priority over start in the same cycle.
REQ-025 SHALL keep read_SRAM_gaus and write_SRAM_fast mutually exclusive; addresses SHALL be 0 whenever their strobe is low.
REQ-026 SHALL latch max_x and max_y at start; changes during a scan SHALL have no effect.

Reset
REQ-027 SHALL on n_rst low immediately force IDLE and drive all outputs (strobes, addresses, fast_wdata, busy, done, corner_count) to 0, including mid-scan.
REQ-028 SHALL require a new start after reset release to resume scanning.

Verification
REQ-029 SHALL verify a flat 8x8 image (all 100), start -> 64 writes all 0, corner_count=0, done at cycle 4*20+60=140 after start.
REQ-030 SHALL verify centre 100 with ring indices 12..15,0..4 at 130 and others at 100 -> corner 1 (wrap run 9); same with indices 0..7 only -> corner 0.
REQ-031 SHALL verify ring equal to 120 with centre 100 (equal to c+THRESHOLD) -> not bright, corner 0; ring at 121 -> corner 1.
REQ-032 SHALL verify max_x=max_y=4 (5x5 image, all border) -> 25 single-cycle writes of 0, no reads, done 25 cycles after busy rises.
REQ-033 SHALL verify abort asserted during READ of the third pixel -> IDLE next cycle, no done, no further strobes; then n_rst low mid-scan -> all outputs 0 asynchronously.
